// File: rtl/spicart_pkg.sv
// rtl/spicart_pkg.sv - shared spicart protocol definitions (FSM states, header layout, fill byte)
package spicart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        LOAD,
        SHIFT,
        CS_END,
        GAP
    } state_t;

    localparam int         CMD_WR_BIT = 7;
    localparam int         HDR_BYTES  = 2;
    localparam logic [7:0] FILL_BYTE  = 8'h00;

endpackage

// File: rtl/spi_shift_byte.sv
// rtl/spi_shift_byte.sv - one SPI mode-0 byte: SCK divider, 3-bit bit counter, MOSI/MISO shift registers
module spi_shift_byte #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       byte_done,
    output logic       last_rise,
    output logic [7:0] rx_next
);

    logic       active;
    logic       tail;
    logic [7:0] div;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic       tick;

    assign tick      = active && (div == 8'(CLK_DIV - 1));
    assign last_rise = tick && !tail && !sck && (bit_cnt == 3'd7);
    assign rx_next   = {rx_sr[6:0], miso};
    assign mosi      = tx_sr[7];

    // tail is the trailing low half-period after the 8th falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= 1'b0;
            tail      <= 1'b0;
            sck       <= 1'b0;
            div       <= 8'd0;
            bit_cnt   <= 3'd0;
            tx_sr     <= 8'd0;
            rx_sr     <= 8'd0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (load) begin
                tx_sr   <= tx_byte;
                active  <= 1'b1;
                tail    <= 1'b0;
                sck     <= 1'b0;
                div     <= 8'd0;
                bit_cnt <= 3'd0;
            end else if (active) begin
                if (!tick) begin
                    div <= div + 8'd1;
                end else begin
                    div <= 8'd0;
                    if (tail) begin
                        active    <= 1'b0;
                        byte_done <= 1'b1;
                    end else if (!sck) begin
                        sck   <= 1'b1;
                        rx_sr <= rx_next;
                    end else begin
                        sck <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            tail  <= 1'b1;
                            tx_sr <= 8'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_sr   <= {tx_sr[6:0], 1'b0};
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/spicart_host.sv
// rtl/spicart_host.sv - spicart SPI initiator; SPICART_HOST_STALL_EN holds in LOAD on write underrun instead of sending 0xFF
module spicart_host
    import spicart_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int CS_GAP     = 4,
    parameter int READ_DUMMY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        wr,
    input  logic [14:0] addr,
    input  logic [7:0]  len,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic        done,
    output logic        underrun,
    output logic        spi_cs,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    state_t      state;
    logic        wr_q;
    logic [14:0] addr_q;
    logic [8:0]  total;
    logic [8:0]  byte_idx;
    logic [15:0] wait_cnt;
    logic        rd_data_q;
    logic        rx_pend;

    logic [8:0]  first_data;
    logic        is_data;
    logic        wr_data;
    logic [7:0]  hdr0;
    logic [7:0]  tx_byte;
    logic        stall;
    logic        load;
    logic        byte_done;
    logic        last_rise;
    logic [7:0]  rx_next;

    always_comb begin
        first_data = 9'(HDR_BYTES) + (wr_q ? 9'd0 : 9'(READ_DUMMY));
        is_data    = byte_idx >= first_data;
        wr_data    = wr_q && is_data;
        hdr0       = {1'b0, addr_q[14:8]};
        hdr0[CMD_WR_BIT] = wr_q;
        tx_byte    = FILL_BYTE;
        if (byte_idx == 9'd0)
            tx_byte = hdr0;
        else if (byte_idx == 9'd1)
            tx_byte = addr_q[7:0];
        else if (wr_data)
            tx_byte = tx_valid ? tx_data : 8'hFF;
    end

`ifdef SPICART_HOST_STALL_EN
    assign stall = (state == LOAD) && wr_data && !tx_valid;
`else
    assign stall = 1'b0;
`endif

    assign load     = (state == LOAD) && !stall;
    assign tx_ready = (state == LOAD) && wr_data && tx_valid;

    spi_shift_byte #(.CLK_DIV(CLK_DIV)) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .tx_byte   (tx_byte),
        .miso      (spi_miso),
        .sck       (spi_sck),
        .mosi      (spi_mosi),
        .byte_done (byte_done),
        .last_rise (last_rise),
        .rx_next   (rx_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_q      <= 1'b0;
            addr_q    <= 15'd0;
            total     <= 9'd0;
            byte_idx  <= 9'd0;
            wait_cnt  <= 16'd0;
            rd_data_q <= 1'b0;
            rx_pend   <= 1'b0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
            spi_cs    <= 1'b0;
        end else begin
            done     <= 1'b0;
            rx_valid <= rx_pend;
            rx_pend  <= 1'b0;
            if (last_rise && rd_data_q) begin
                rx_data <= rx_next;
                rx_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        wr_q     <= wr;
                        addr_q   <= addr;
                        total    <= 9'(HDR_BYTES) + (wr ? 9'd0 : 9'(READ_DUMMY))
                                    + {len == 8'd0, len};
                        byte_idx <= 9'd0;
                        wait_cnt <= 16'd0;
                        busy     <= 1'b1;
                        underrun <= 1'b0;
                        spi_cs   <= 1'b1;
                        state    <= CS_SETUP;
                    end
                end
                CS_SETUP: begin
                    if (wait_cnt == 16'(CLK_DIV - 1))
                        state <= LOAD;
                    else
                        wait_cnt <= wait_cnt + 16'd1;
                end
                LOAD: begin
                    if (!stall) begin
                        byte_idx  <= byte_idx + 9'd1;
                        rd_data_q <= !wr_q && is_data;
                        if (wr_data && !tx_valid)
                            underrun <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (byte_done) begin
                        if (byte_idx == total) begin
                            spi_cs <= 1'b0;
                            state  <= CS_END;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                CS_END: begin
                    wait_cnt <= 16'd0;
                    state    <= GAP;
                end
                GAP: begin
                    if (int'(wait_cnt) + 1 >= CS_GAP) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spicart_host.sv
// tb/tb_spicart_host.sv - directed self-checking bench for spicart_host with a mode-0 responder model
module tb_spicart_host;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        wr = 1'b0;
    logic [14:0] addr = 15'd0;
    logic [7:0]  len = 8'd0;
    logic [7:0]  tx_data = 8'd0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        busy;
    logic        done;
    logic        underrun;
    logic        spi_cs;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;

    int errors = 0;
    int checks = 0;

    spicart_host dut (
        .clk(clk), .rst_n(rst_n), .start(start), .wr(wr), .addr(addr), .len(len),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
        .underrun(underrun), .spi_cs(spi_cs), .spi_sck(spi_sck),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int         rise_cnt;
    int         bitn;
    logic [7:0] mosi_sr;
    logic [7:0] mosi_q[$];
    logic [7:0] rx_q[$];
    int         done_cnt;
    int         txr_cnt;
    int         cs_fall_cnt;
    logic       cs_prev = 1'b0;
    logic [7:0] tx_mem [0:255];
    int         tx_idx;
    int         tx_avail;
    logic [7:0] resp [0:255];
    logic       rd_active = 1'b0;
    int         rd_len = 0;

    always @(posedge spi_sck) begin
        rise_cnt = rise_cnt + 1;
        mosi_sr  = {mosi_sr[6:0], spi_mosi};
        bitn     = bitn + 1;
        if (bitn == 8) begin
            mosi_q.push_back(mosi_sr);
            bitn = 0;
        end
    end

    // data bytes start after 2 header bytes and one dummy byte (24 rises)
    always_comb begin
        spi_miso = 1'b0;
        if (rd_active && rise_cnt >= 24 && rise_cnt < 24 + 8 * rd_len)
            spi_miso = resp[(rise_cnt - 24) >> 3][3'(7 - ((rise_cnt - 24) & 7))];
    end

    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (done) done_cnt = done_cnt + 1;
        if (tx_ready) txr_cnt = txr_cnt + 1;
        if (cs_prev && !spi_cs) cs_fall_cnt = cs_fall_cnt + 1;
        cs_prev = spi_cs;
    end

    always @(negedge clk) begin
        if (tx_ready) begin
            @(posedge clk);
            #1;
            tx_idx   = tx_idx + 1;
            tx_data  = tx_mem[tx_idx[7:0]];
            tx_valid = tx_idx < tx_avail;
        end
    end

    task automatic clear_counts();
        rise_cnt = 0; bitn = 0; mosi_sr = 8'd0;
        mosi_q.delete(); rx_q.delete();
        done_cnt = 0; txr_cnt = 0; cs_fall_cnt = 0;
    endtask

    task automatic set_tx(input int avail);
        tx_idx   = 0;
        tx_avail = avail;
        tx_data  = tx_mem[0];
        tx_valid = avail > 0;
    endtask

    task automatic run_frame(input logic w, input logic [14:0] a, input logic [7:0] l, input int limit);
        rd_active = !w;
        rd_len    = (l == 8'd0) ? 256 : int'(l);
        clear_counts();
        @(negedge clk);
        start = 1'b1; wr = w; addr = a; len = l;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < limit && done_cnt == 0; c++) @(negedge clk);
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL frame_timeout: done not seen within %0d cycles (got %0d done, need 1)", limit, done_cnt);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_mosi(input string name, input logic [7:0] exp[$]);
        checks++;
        if (mosi_q.size() !== exp.size()) begin
            errors++;
            $display("FAIL %s_len: got %0d bytes, need %0d", name, mosi_q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (mosi_q[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL %s_byte%0d: got %h, need %h", name, i, mosi_q[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_counts();
        set_tx(0);
        repeat (3) @(negedge clk);
        checks++;
        if ({spi_cs, spi_sck, spi_mosi, busy, done, tx_ready, rx_valid, underrun} !== 8'd0) begin
            errors++;
            $display("FAIL reset_flags: got %b, need 00000000",
                     {spi_cs, spi_sck, spi_mosi, busy, done, tx_ready, rx_valid, underrun});
        end
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_data: got %h, need 00", rx_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read();
        resp[0] = 8'h34; resp[1] = 8'h35;
        set_tx(0);
        run_frame(1'b0, 15'h1234, 8'd2, 2000);
        check_mosi("read_mosi", '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00});
        checks++;
        if (rx_q.size() !== 2 || rx_q[0] !== 8'h34 || rx_q[1] !== 8'h35) begin
            errors++;
            $display("FAIL read_rx: got %0d bytes first %h, need 2 bytes 34 35", rx_q.size(),
                     rx_q.size() > 0 ? rx_q[0] : 8'hxx);
        end
        checks++;
        if (rise_cnt !== 40) begin errors++; $display("FAIL read_rises: got %0d, need 40", rise_cnt); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL read_done: got %0d, need 1", done_cnt); end
        checks++;
        if (busy !== 1'b0 || spi_cs !== 1'b0) begin
            errors++; $display("FAIL read_idle: got busy=%b cs=%b, need 0 0", busy, spi_cs);
        end
    endtask

    task automatic test_write();
        for (int i = 0; i < 4; i++) tx_mem[i] = 8'hA0 + 8'(i);
        set_tx(4);
        run_frame(1'b1, 15'h0000, 8'd4, 2000);
        check_mosi("write_mosi", '{8'h80, 8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3});
        checks++;
        if (txr_cnt !== 4) begin errors++; $display("FAIL write_tx_ready: got %0d, need 4", txr_cnt); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL write_underrun: got %b, need 0", underrun); end
        checks++;
        if (rise_cnt !== 48) begin errors++; $display("FAIL write_rises: got %0d, need 48", rise_cnt); end
    endtask

    task automatic test_len0();
        logic [7:0] exp[$];
        for (int i = 0; i < 256; i++) tx_mem[i] = 8'(i);
        set_tx(256);
        run_frame(1'b1, 15'h2A55, 8'd0, 20000);
        exp.push_back(8'hAA); exp.push_back(8'h55);
        for (int i = 0; i < 256; i++) exp.push_back(8'(i));
        check_mosi("len0_mosi", exp);
        checks++;
        if (rise_cnt !== 2064) begin errors++; $display("FAIL len0_rises: got %0d, need 2064", rise_cnt); end
        checks++;
        if (txr_cnt !== 256) begin errors++; $display("FAIL len0_tx_ready: got %0d, need 256", txr_cnt); end
        checks++;
        if (cs_fall_cnt !== 1 || done_cnt !== 1) begin
            errors++; $display("FAIL len0_cs_done: got cs_falls=%0d done=%0d, need 1 1", cs_fall_cnt, done_cnt);
        end
    endtask

    task automatic test_underrun();
        tx_mem[0] = 8'h5A; tx_mem[1] = 8'h5B;
        set_tx(1);
`ifdef SPICART_HOST_STALL_EN
        fork
            run_frame(1'b1, 15'h0102, 8'd2, 4000);
            begin
                repeat (80) @(negedge clk);
                tx_avail = 2;
                tx_data  = tx_mem[1];
                tx_valid = 1'b1;
            end
        join
        check_mosi("underrun_mosi", '{8'h81, 8'h02, 8'h5A, 8'h5B});
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_flag: got %b, need 0", underrun); end
`else
        run_frame(1'b1, 15'h0102, 8'd2, 4000);
        check_mosi("underrun_mosi", '{8'h81, 8'h02, 8'h5A, 8'hFF});
        checks++;
        if (txr_cnt !== 1) begin errors++; $display("FAIL underrun_tx_ready: got %0d, need 1", txr_cnt); end
        repeat (10) @(negedge clk);
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_flag: got %b, need 1", underrun); end
`endif
        set_tx(0);
        rd_active = 1'b0;
        @(negedge clk); start = 1'b1; wr = 1'b0; addr = 15'h0001; len = 8'd1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        checks++;
        if (underrun !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL underrun_clear: got underrun=%b busy=%b, need 0 1", underrun, busy);
        end
        for (int c = 0; c < 2000 && busy; c++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int c;
        resp[0] = 8'hC3; resp[1] = 8'h3C;
        set_tx(0);
        rd_active = 1'b1; rd_len = 2;
        clear_counts();
        @(negedge clk); start = 1'b1; wr = 1'b0; addr = 15'h1234; len = 8'd2;
        @(negedge clk); start = 1'b0;
        c = 0;
        while (rise_cnt < 11 && c < 2000) begin @(negedge clk); c++; end
        checks++;
        if (rise_cnt < 11) begin errors++; $display("FAIL mid_reset_wait: got %0d rises, need 11", rise_cnt); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({spi_cs, spi_sck, busy} !== 3'b000) begin
            errors++; $display("FAIL mid_reset_async: got cs/sck/busy=%b, need 000", {spi_cs, spi_sck, busy});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(1'b0, 15'h1234, 8'd2, 2000);
        check_mosi("mid_reset_mosi", '{8'h12, 8'h34, 8'h00, 8'hC3 & 8'h00, 8'h00});
        checks++;
        if (rx_q.size() !== 2 || rx_q[0] !== 8'hC3 || rx_q[1] !== 8'h3C || rise_cnt !== 40) begin
            errors++; $display("FAIL mid_reset_frame: got %0d rx bytes, %0d rises, need 2 bytes C3 3C, 40 rises",
                                rx_q.size(), rise_cnt);
        end
    endtask

    task automatic test_busy_start();
        resp[0] = 8'h77;
        set_tx(0);
        fork
            run_frame(1'b0, 15'h0456, 8'd1, 2000);
            begin
                repeat (30) @(negedge clk);
                start = 1'b1; wr = 1'b1; addr = 15'h7FFF; len = 8'd5;
                @(negedge clk);
                start = 1'b0;
            end
        join
        repeat (50) @(negedge clk);
        check_mosi("busy_mosi", '{8'h04, 8'h56, 8'h00, 8'h00});
        checks++;
        if (done_cnt !== 1 || rise_cnt !== 32) begin
            errors++; $display("FAIL busy_single: got done=%0d rises=%0d, need 1 32", done_cnt, rise_cnt);
        end
        checks++;
        if (busy !== 1'b0 || rx_q.size() !== 1 || rx_q[0] !== 8'h77) begin
            errors++; $display("FAIL busy_rx: got busy=%b rx_bytes=%0d, need 0 and one byte 77", busy, rx_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_len0();
        test_underrun();
        test_reset_mid();
        test_busy_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
